// File: rtl/gate_arb_pkg.sv
// Shared constants for the round-robin gate arbiter: opcodes, FSM encoding
// and the round-robin winner search.
package gate_arb_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // First set request bit scanning ptr, ptr+1, ... wrapping at nreq-1.
    // Sized for the largest supported requester count (8); ptr < nreq assumed.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int nreq);
        logic found;
        int   idx;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = int'(ptr) + i;
            if (idx >= nreq) idx = idx - nreq;
            if (i < nreq && !found && req[idx[2:0]]) begin
                rr_pick = idx[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/gate_alu.sv
// Combinational W-bit logic unit shared by all requesters (AND/OR/XOR/NAND).
module gate_alu
    import gate_arb_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_rr_arbiter.sv
// Round-robin sequencer sharing one gate_alu among NREQ requesters.
// Build with GATE_ARB_STATS_EN to get a saturating completed-transaction counter.
module gate_rr_arbiter
    import gate_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 1,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    input  logic [NREQ*2-1:0] opcode,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ack,
    output logic [7:0]        txn_count
);

    // Handshake: res_valid rises with the result and stays high, with res_data and
    // res_id frozen, until res_ack is sampled high; that edge completes the transfer.

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] pick;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     op_q;
    logic [W-1:0]   alu_y;

    assign pick = IDW'(rr_pick(8'(req), 3'(ptr), NREQ));

    gate_alu #(.W(W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win_id    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt    <= NREQ'(1) << pick;
                        a_q    <= op_a[pick*W +: W];
                        b_q    <= op_b[pick*W +: W];
                        op_q   <= opcode[pick*2 +: 2];
                        win_id <= pick;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    gnt       <= '0;
                    res_data  <= alu_y;
                    res_id    <= win_id;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    // The winner drops to lowest priority for the next round.
                    if (res_ack) begin
                        res_valid <= 1'b0;
                        ptr       <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GATE_ARB_STATS_EN
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (state == ST_RESP && res_valid && res_ack && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign txn_count = count_q;
`else
    assign txn_count = 8'd0;
`endif

endmodule

// File: tb/tb_gate_rr_arbiter.sv
// Self-checking bench for gate_rr_arbiter: reset, round-robin order, a vector
// table, mid-transaction reset and randomized transactions against a model.
module tb_gate_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ*2-1:0] opcode;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ack;
    logic [7:0]        txn_count;

    int total = 0;
    int bad   = 0;

    int model_ptr = 0;
    int model_cnt = 0;
    logic [IDW-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0]   r;
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        logic [NREQ*2-1:0] opc;
        int                delay;
        logic [IDW-1:0]    exp_id;
        logic [W-1:0]      exp_data;
    } vec_t;

    vec_t tbl[8];

    gate_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ack   (res_ack),
        .txn_count (txn_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Reference model: round-robin scan and logic function from first principles.
    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_gate(input logic [NREQ*W-1:0] a,
                                                input logic [NREQ*W-1:0] b,
                                                input logic [NREQ*2-1:0] opc,
                                                input int idx);
        logic [W-1:0] fa, fb;
        logic [1:0]   fo;
        fa = W'(a >> (idx * W));
        fb = W'(b >> (idx * W));
        fo = 2'(opc >> (idx * 2));
        case (fo)
            2'b00:   return fa & fb;
            2'b01:   return fa | fb;
            2'b10:   return fa ^ fb;
            default: return ~(fa & fb);
        endcase
    endfunction

    task automatic model_reset;
        model_ptr = 0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int id);
        model_ptr = (id + 1) % NREQ;
`ifdef GATE_ARB_STATS_EN
        if (model_cnt < 255) model_cnt++;
`endif
    endtask

    // ---------------- driver: one full transaction from IDLE ----------------
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] a,
                          input logic [NREQ*W-1:0] b, input logic [NREQ*2-1:0] opc,
                          input int delay, input logic [IDW-1:0] exp_id,
                          input logic [W-1:0] exp_data, input string tag);
        req = r; op_a = a; op_b = b; opcode = opc;
        res_ack = 1'($urandom_range(0, 1));
        tick;
        check({tag, "_gnt"}, gnt, onehot(int'(exp_id)));
        check({tag, "_valid_at_gnt"}, res_valid, 0);
        // Operands and requests are scrambled after the grant edge.
        op_a = NREQ*W'($urandom); op_b = NREQ*W'($urandom); opcode = NREQ*2'($urandom);
        req = NREQ'($urandom);
        res_ack = 1'($urandom_range(0, 1));
        tick;
        check({tag, "_gnt_clear"}, gnt, 0);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_id"}, res_id, exp_id);
        res_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            req = NREQ'($urandom);
            tick;
            check({tag, "_hold_valid"}, res_valid, 1);
            check({tag, "_hold_data"}, res_data, exp_data);
            check({tag, "_hold_id"}, res_id, exp_id);
            check({tag, "_hold_no_gnt"}, gnt, 0);
        end
        res_ack = 1'b1;
        req = '0;
        tick;
        res_ack = 1'b0;
        model_accept(int'(exp_id));
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_data_kept"}, res_data, exp_data);
        check({tag, "_txn_count"}, txn_count, model_cnt);
    endtask

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        logic [NREQ-1:0]   r;
        logic [NREQ*W-1:0] a, b;
        logic [NREQ*2-1:0] opc;
        int id, ngr;
        logic [IDW-1:0] e;

        rst_n = 1'b0; req = '1; res_ack = 1'b0;
        op_a = '0; op_b = '0; opcode = '0;

        // Reset with all requests high, then round-robin with ack held high.
        tick; tick;
        model_reset();
        check("rst_gnt", gnt, 0);
        check("rst_valid", res_valid, 0);
        check("rst_txn_count", txn_count, 0);
        check("rst_data", res_data, 0);
        check("rst_id", res_id, 0);

        rst_n = 1'b1; res_ack = 1'b1;
        ngr = 0;
        for (int cyc = 0; cyc < 40 && !(ngr == 5 && exp_q.size() == 0); cyc++) begin
            tick;
            check("rr_onehot", 32'($countones(gnt) <= 1), 1);
            if (gnt != 0) begin
                check("rr_order", gnt, onehot(ngr % NREQ));
                exp_q.push_back(IDW'(ngr % NREQ));
                ngr++;
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("rr_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rr_res_id", res_id, e);
                end
            end
        end
        check("rr_grants", ngr, 5);
        check("rr_queue_empty", exp_q.size(), 0);
        req = '0;
        tick;
        res_ack = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) model_accept(k % NREQ);
        check("rr_txn_count", txn_count, model_cnt);

        // Vector table, starting from a fresh reset (ptr=0).
        rst_n = 1'b0; tick; rst_n = 1'b1; model_reset();
        tbl[0] = '{4'b0100, 8'h10, 8'h10, 8'h00, 0, 2'd2, 2'b01};
        tbl[1] = '{4'b1111, 8'hE4, 8'hBD, 8'hAA, 1, 2'd3, 2'b01};
        tbl[2] = '{4'b1111, 8'hE4, 8'hBD, 8'hFF, 0, 2'd0, 2'b11};
        tbl[3] = '{4'b0001, 8'hE4, 8'hBD, 8'h55, 2, 2'd0, 2'b01};
        tbl[4] = '{4'b1010, 8'hE4, 8'hBD, 8'h00, 0, 2'd1, 2'b01};
        tbl[5] = '{4'b1001, 8'hE4, 8'hBD, 8'hFF, 0, 2'd3, 2'b01};
        tbl[6] = '{4'b0010, 8'h04, 8'h04, 8'hAA, 5, 2'd1, 2'b00};
        tbl[7] = '{4'b0101, 8'hE4, 8'hBD, 8'h00, 1, 2'd2, 2'b10};
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].opc, tbl[i].delay,
                   tbl[i].exp_id, tbl[i].exp_data, $sformatf("tbl%0d", i));
        end

        // Reset while in EXEC: the pending result must never appear.
        req = 4'b0100; op_a = 8'hFF; op_b = 8'hFF; opcode = 8'h00;
        tick;
        check("midrst_gnt", gnt, 4'b0100);
        rst_n = 1'b0; req = '0;
        tick;
        model_reset();
        check("midrst_valid", res_valid, 0);
        check("midrst_gnt_clear", gnt, 0);
        check("midrst_data", res_data, 0);
        check("midrst_id", res_id, 0);
        check("midrst_txn_count", txn_count, 0);
        rst_n = 1'b1; res_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("midrst_no_result", res_valid, 0);
        end
        res_ack = 1'b0;
        do_txn(4'b1111, 8'hE4, 8'hBD, 8'h55, 0, 2'd0, 2'b01, "midrst_ptr0");

        // Randomized transactions against the model; long enough to saturate txn_count.
        rst_n = 1'b0; tick; rst_n = 1'b1; model_reset();
        for (int n = 0; n < 260; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                req = '0; res_ack = 1'($urandom_range(0, 1));
                op_a = NREQ*W'($urandom); op_b = NREQ*W'($urandom);
                tick; tick;
                check("idle_gnt", gnt, 0);
                check("idle_valid", res_valid, 0);
                res_ack = 1'b0;
            end
            r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            a   = NREQ*W'($urandom);
            b   = NREQ*W'($urandom);
            opc = NREQ*2'($urandom);
            id  = model_pick(r);
            do_txn(r, a, b, opc, $urandom_range(0, 3), IDW'(id),
                   model_gate(a, b, opc, id), "rand");
        end
`ifdef GATE_ARB_STATS_EN
        check("stats_saturated", txn_count, 255);
`else
        check("stats_disabled", txn_count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
